// File: rtl/fp32_pkg.sv
// Shared single-precision definitions used by the integer encoder and
// the FP datapath stages that follow it.
`timescale 1ns/1ps
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised mantissa.
// A mantissa carry-out rolls the value to the next binade: the mantissa
// wraps to zero and the exponent is bumped by one.
`timescale 1ns/1ps
module fp_round_rne
    import fp32_pkg::*;
(
    input  logic [MAN_W-1:0] man,
    input  logic             guard,
    input  logic             sticky,
    input  logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] man_out,
    output logic [EXP_W-1:0] exp_out
);

    logic         inc;
    logic [MAN_W:0] sum;

    // Round up above the halfway point, or exactly at it when the mantissa is odd
    assign inc     = guard & (sticky | man[0]);
    assign sum     = {1'b0, man} + {{MAN_W{1'b0}}, inc};
    assign man_out = sum[MAN_W-1:0];
    assign exp_out = exp + {{(EXP_W-1){1'b0}}, sum[MAN_W]};

endmodule

// File: rtl/int_to_fp32.sv
// Sequential 32-bit integer (signed or unsigned) to IEEE754 single encoder.
// The magnitude is normalised one bit per cycle, then rounded to nearest even
// and presented behind a valid/ready handshake.
`timescale 1ns/1ps
module int_to_fp32 #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_BIAS   = 127
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    import fp32_pkg::*;

    // Exponent of a magnitude whose MSB already sits in bit 31
    localparam logic [EXP_W-1:0] EXP_START = EXP_W'(EXP_BIAS + DATA_WIDTH - 1);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mag;
    logic [EXP_W-1:0]        exp_q;
    logic                    sign;
    logic                    zero_flag;
    logic                    neg_in;

    logic [MAN_W-1:0]        rnd_man;
    logic [EXP_W-1:0]        rnd_exp;
    fp32_t                   result;

    assign neg_in = in_signed & in_data[DATA_WIDTH-1];

    fp_round_rne u_round (
        .man     (mag[30:8]),
        .guard   (mag[7]),
        .sticky  (|mag[6:0]),
        .exp     (exp_q),
        .man_out (rnd_man),
        .exp_out (rnd_exp)
    );

    // Assemble the output word; a zero input always encodes as +0
    always_comb begin
        result = '0;
        if (!zero_flag) begin
            result.sign = sign;
            result.exp  = rnd_exp;
            result.man  = rnd_man;
        end
    end

    // Conversion FSM: accept, normalise bit by bit, round, hold until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            mag       <= '0;
            exp_q     <= '0;
            sign      <= 1'b0;
            zero_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign      <= neg_in;
                        mag       <= neg_in ? (~in_data + DATA_WIDTH'(1)) : in_data;
                        exp_q     <= EXP_START;
                        zero_flag <= 1'b0;
                        in_ready  <= 1'b0;
                        state     <= NORM;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        zero_flag <= 1'b1;
                        state     <= ROUND;
                    end else if (mag[DATA_WIDTH-1]) begin
                        state <= ROUND;
                    end else begin
                        mag   <= mag << 1;
                        exp_q <= exp_q - EXP_W'(1);
                    end
                end
                ROUND: begin
                    out_data  <= result;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fp32.sv
// Directed bench for int_to_fp32: hand-computed IEEE754 results, latency,
// backpressure and reset behaviour.
`timescale 1ns/1ps
module tb_int_to_fp32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checkCount = 0;
    int failCount  = 0;

    always #5 clk = ~clk;

    int_to_fp32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Single comparison point: counts every check, reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Called at the first negedge after accept; returns cycles until out_valid
    task automatic waitOutput(output int cycles);
        cycles = 1;
        while (out_valid !== 1'b1 && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Present one operand with out_ready high and check result and latency
    task automatic applyStimulus(input string tag, input logic [31:0] data, input logic sgn,
                                 input logic [31:0] expected, input int expLatency);
        int cycles;
        @(negedge clk);
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_data   = data;
        in_signed = sgn;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_signed = 1'b1;
        waitOutput(cycles);
        checkOutput({tag, " latency"}, 32'(cycles), 32'(expLatency));
        checkOutput({tag, " data"}, out_data, expected);
        @(negedge clk);
        checkOutput({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int cycles;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data", out_data, 32'h0);
        rst = 1'b0;

        applyStimulus("five",          32'd5,        1'b0, 32'h40A00000, 32);
        applyStimulus("neg15 signed",  32'hFFFFFFF1, 1'b1, 32'hC1700000, 31);
        applyStimulus("neg15 unsigned",32'hFFFFFFF1, 1'b0, 32'h4F800000, 3);
        applyStimulus("max unsigned",  32'hFFFFFFFF, 1'b0, 32'h4F800000, 3);
        applyStimulus("tie even",      32'd16777217, 1'b0, 32'h4B800000, 10);
        applyStimulus("tie odd",       32'd16777219, 1'b0, 32'h4B800002, 10);
        applyStimulus("min signed",    32'h80000000, 1'b1, 32'hCF000000, 3);
        applyStimulus("zero signed",   32'h00000000, 1'b1, 32'h00000000, 3);
        applyStimulus("one",           32'd1,        1'b0, 32'h3F800000, 34);
        applyStimulus("minus one",     32'hFFFFFFFF, 1'b1, 32'hBF800000, 34);

        // Backpressure: result held in DONE, extra input refused
        @(negedge clk);
        in_data   = 32'd5;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_data = 32'd7;
        waitOutput(cycles);
        checkOutput("bp latency", 32'(cycles), 32'd32);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp out_data", out_data, 32'h40A00000);
            checkOutput("bp in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        checkOutput("bp release out_valid", 32'(out_valid), 32'd0);
        checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
        applyStimulus("after bp", 32'd7, 1'b0, 32'h40E00000, 32);

        // Reset mid-NORM discards the conversion
        @(negedge clk);
        in_data   = 32'd1;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst norm out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst norm out_data", out_data, 32'h0);
        checkOutput("rst norm in_ready", 32'(in_ready), 32'd1);
        applyStimulus("after rst", 32'd7, 1'b0, 32'h40E00000, 32);

        // Reset in DONE drops the pending result
        @(negedge clk);
        in_data   = 32'd3;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        waitOutput(cycles);
        checkOutput("rst done pending", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst done out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst done out_data", out_data, 32'h0);
        checkOutput("rst done in_ready", 32'(in_ready), 32'd1);
        applyStimulus("after rst done", 32'd3, 1'b0, 32'h40400000, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/int_to_fp32.md
Name: int_to_fp32

Overview:
- Sequential encoder that converts a 32-bit integer, signed or unsigned, into an IEEE754 single-precision word.
- It produces the operand format that the ADD unit consumes.
- Normalisation is iterative, one bit per cycle, under an FSM.
- Rounding is round-to-nearest-even.
- Valid/ready handshakes on input and output let it sit in front of the FP datapath.

Parameters:
DATA_WIDTH, 32, integer input width and float output width; only 32 is supported.
EXP_BIAS, 127, IEEE754 single exponent bias.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input word present
in_ready  output  1  block can accept; high only in IDLE
in_data  input  32  integer operand
in_signed  input  1  1 = two's complement, 0 = unsigned; sampled with in_data
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  32  IEEE754 result {sign, exp[7:0], man[22:0]}

Behaviour:
- Reset: rst sampled high at a clock edge forces:
  - state=IDLE, in_ready=1, out_valid=0, out_data=0;
  - internal mag=0, exp=0, sign=0, zero flag=0.
  - This holds in any state, including mid-NORM and DONE with a pending result. The pending result is discarded.
- States: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch sign = in_signed&in_data[31].
  - mag = sign ? (~in_data+1) : in_data, as a 32-bit unsigned value. -2^31 gives mag=0x80000000.
  - exp = EXP_BIAS+31 = 158. Go to NORM.
- NORM, one evaluation per cycle:
  - mag==0: set zero flag, go to ROUND.
  - Else if mag[31]: go to ROUND.
  - Else: mag<<=1, exp-=1, stay.
  - NORM cycles = leading_zeros(mag)+1; for zero, 1 cycle.
- ROUND:
  - man = mag[30:8], guard = mag[7], sticky = |mag[6:0].
  - Increment when guard && (sticky || man[0]).
  - If the increment carries out of man: man=0, exp+=1.
  - Zero flag: result is 0x00000000 with sign forced to 0, so -0 is never produced.
  - Register out_data, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data is held stable while !out_ready.
  - When out_ready is sampled high: out_valid=0 next cycle, go to IDLE.
  - No new input is accepted in the same cycle as the output handshake.
- Latency: accept at the edge ending cycle T; out_valid is first high in cycle T+lz+3, where lz is the leading-zero count (lz=0 for zero input). Maximum 34 cycles (mag=1).
- Throughput: one conversion in flight; no overlap.
- Overflow: not possible. The maximum result is 0x4F800000 (2^32), from unsigned 0xFFFFFFFF rounding up. No NaN/Inf/denormal outputs.
- in_data/in_signed are ignored outside IDLE. in_valid held during busy states has no effect.
- Simultaneous rst and handshake: rst wins.

Decomposition:
- Package fp32_pkg:
  - constants EXP_W=8, MAN_W=23, EXP_BIAS=127;
  - typedef fp32_t packed struct {sign, exp, man};
  - state enum {IDLE, NORM, ROUND, DONE}.
- One combinational sub-module, fp_round_rne:
  - inputs: man[22:0], guard, sticky, exp[7:0];
  - outputs: rounded man and exp, handling the carry.
  - Reused later by the adder output stage.

Test Plan:
- in_data=5, in_signed=0, out_ready=1 -> out_data=0x40A00000; out_valid rises 32 cycles after accept (lz=29).
- in_data=-15 (0xFFFFFFF1), in_signed=1 -> 0xC1700000. Same word with in_signed=0 -> 0x4F800000 (rounds 4294967281 up to 2^32).
- Rounding: 16777217 -> 0x4B800000 (tie, even, no increment). 16777219 -> 0x4B800002 (tie, odd, increment). 0x80000000 with in_signed=1 -> 0xCF000000.
- Zero: in_data=0 with in_signed=1 -> 0x00000000; out_valid 3 cycles after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, and a new in_valid is not accepted. Release -> out_valid drops next cycle, in_ready=1.
- Reset mid-NORM (in_data=1, assert rst at cycle 5) -> next cycle out_valid=0, out_data=0, in_ready=1. A following conversion of 7 returns 0x40E00000.
